// File: rtl/bfp16_col_drain.sv
// bfp16_col_drain: captures PE column results into a tagged FIFO for writeback.
// Optional Inf/NaN tracking is enabled with `define BFP16_DRAIN_NAN_CHECK_EN.
module bfp16_col_drain #(
   parameter int DATA_TYPE = 16,
   parameter int NUM_ROWS  = 4,
   parameter int DEPTH     = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   input  logic [DATA_TYPE-1:0]        in_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [DATA_TYPE-1:0]        m_data,
   output logic [$clog2(NUM_ROWS)-1:0] m_row,
   output logic                        m_last,
   output logic                        done,
   output logic                        overflow,
   output logic                        busy
`ifdef BFP16_DRAIN_NAN_CHECK_EN
   ,
   output logic                        nan_seen,
   output logic                        m_nan
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(NUM_ROWS);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_TYPE-1:0] mem_data_q [DEPTH];
   logic [RW-1:0]        mem_row_q  [DEPTH];
   logic [DEPTH-1:0]     mem_last_q;
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [AW:0]          count_q, count_d;
   logic [RW-1:0]        row_cnt_q, row_cnt_d;
   logic                 overflow_q, done_q, done_d;
   logic                 push, pop, full, row_last, head_last;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign m_valid   = (count_q != '0);
   assign pop       = m_valid & m_ready;
   assign push      = in_valid & (~full | pop);
   assign row_last  = (row_cnt_q == RW'(NUM_ROWS - 1));
   assign head_last = m_valid & mem_last_q[rd_ptr_q];

   // Head word is read straight from the storage array; zero when empty.
   assign m_data   = m_valid ? mem_data_q[rd_ptr_q] : '0;
   assign m_row    = m_valid ? mem_row_q[rd_ptr_q] : '0;
   assign m_last   = head_last;
   assign done     = done_q;
   assign overflow = overflow_q;
   assign busy     = (state_q != IDLE) | m_valid;

   // Next occupancy, row index and done pulse.
   always_comb begin
      count_d   = count_q;
      row_cnt_d = row_cnt_q;
      done_d    = pop & head_last;
      if (push & ~pop) count_d = count_q + 1'b1;
      else if (pop & ~push) count_d = count_q - 1'b1;
      if (in_valid) row_cnt_d = row_last ? '0 : row_cnt_q + 1'b1;
   end

   // Stream phase tracking.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, COLLECT: begin
            if (in_valid) state_d = row_last ? DRAIN : COLLECT;
         end
         DRAIN: begin
            if (pop & head_last) begin
               if (in_valid) state_d = row_last ? DRAIN : COLLECT;
               else state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers: pointers, count, row counter, flags, state.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         row_cnt_q  <= '0;
         overflow_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         row_cnt_q <= row_cnt_d;
         done_q    <= done_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (in_valid & ~push) overflow_q <= 1'b1;
      end
   end

   // Entry storage; stale contents are masked by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= in_data;
         mem_row_q[wr_ptr_q]  <= row_cnt_q;
         mem_last_q[wr_ptr_q] <= row_last;
      end
   end

`ifdef BFP16_DRAIN_NAN_CHECK_EN
   logic             nan_seen_q;
   logic [DEPTH-1:0] mem_nan_q;
   logic             in_nan;

   assign in_nan   = (in_data[14:7] == 8'hFF);
   assign nan_seen = nan_seen_q;
   assign m_nan    = m_valid & mem_nan_q[rd_ptr_q];

   // Sticky Inf/NaN flag over accepted words.
   always_ff @(posedge clk) begin
      if (!rst) nan_seen_q <= 1'b0;
      else if (push & in_nan) nan_seen_q <= 1'b1;
   end

   // Per-entry Inf/NaN tag.
   always_ff @(posedge clk) begin
      if (!rst) mem_nan_q <= '0;
      else if (push) mem_nan_q[wr_ptr_q] <= in_nan;
   end
`endif

endmodule

// File: tb/tb_bfp16_col_drain.sv
// Directed testbench for bfp16_col_drain.
// Inputs change 1ns after a rising edge; outputs are checked there.
module tb_bfp16_col_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in_data;
   logic        m_valid;
   logic        m_ready;
   logic [15:0] m_data;
   logic [1:0]  m_row;
   logic        m_last;
   logic        done;
   logic        overflow;
   logic        busy;
`ifdef BFP16_DRAIN_NAN_CHECK_EN
   logic        nan_seen;
   logic        m_nan;
`endif

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bfp16_col_drain #(.DATA_TYPE(16), .NUM_ROWS(4), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_row    (m_row),
      .m_last   (m_last),
      .done     (done),
      .overflow (overflow),
      .busy     (busy)
`ifdef BFP16_DRAIN_NAN_CHECK_EN
      ,
      .nan_seen (nan_seen),
      .m_nan    (m_nan)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [15:0] w2 [4];
   logic [15:0] seq [7];
   logic [1:0]  srow [7];

   initial begin
      w2 = '{16'h3F80, 16'h4040, 16'h4100, 16'h449B};
      rst = 1'b0; in_valid = 1'b0; in_data = '0; m_ready = 1'b0;

      // reset state
      step(); step();
      check("rst_valid", m_valid, 0);
      check("rst_data", m_data, 0);
      check("rst_row", m_row, 0);
      check("rst_last", m_last, 0);
      check("rst_done", done, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      rst = 1'b1;

      // basic vector, streaming
      m_ready = 1'b1; in_valid = 1'b1; in_data = 16'h461B;
      for (int i = 0; i < 4; i++) begin
         step();
         check("v1_valid", m_valid, 1);
         check("v1_data", m_data, 16'h461B);
         check("v1_row", m_row, i);
         check("v1_last", m_last, (i == 3));
         check("v1_done", done, 0);
      end
      in_valid = 1'b0;
      step();
      check("v1_donep", done, 1);
      check("v1_empty", m_valid, 0);
      step();
      check("v1_done1", done, 0);
      check("v1_ovf", overflow, 0);
      check("v1_busy", busy, 0);

      // backpressure and stability
      m_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = w2[i];
         step();
         check("bp_head", m_data, 16'h3F80);
      end
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("bp_hold", m_data, 16'h3F80);
         check("bp_row", m_row, 0);
         check("bp_valid", m_valid, 1);
      end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("bp_pop", m_data, w2[i]);
         check("bp_prow", m_row, i);
         step();
      end
      check("bp_done", done, 1);
      check("bp_empty", m_valid, 0);
      m_ready = 1'b0;

      // overflow
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = 16'h1000 + 16'(i);
         step();
         check("of_flag", overflow, (i == 4));
      end
      in_valid = 1'b0;
      step();
      check("of_sticky", overflow, 1);
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("of_pop", m_data, 16'h1000 + 16'(i));
         check("of_prow", m_row, i);
         step();
      end
      check("of_done", done, 1);
      in_valid = 1'b1; in_data = 16'hABCD;
      step();
      check("of_nxt_v", m_valid, 1);
      check("of_nxt_d", m_data, 16'hABCD);
      check("of_nxt_row", m_row, 1);
      check("of_nxt_last", m_last, 0);
      check("of_sticky2", overflow, 1);
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("of_rst_ovf", overflow, 0);
      check("of_rst_v", m_valid, 0);
      rst = 1'b1;

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < 4; i++) begin
         seq[i] = 16'h2000 + 16'(i);
         srow[i] = 2'(i);
      end
      for (int i = 0; i < 3; i++) begin
         seq[4+i] = 16'h3000 + 16'(i);
         srow[4+i] = 2'(i);
      end
      m_ready = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_data = seq[i];
         step();
      end
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("fs_head", m_data, seq[i]);
         check("fs_row", m_row, srow[i]);
         in_data = seq[4+i];
         step();
         check("fs_ovf", overflow, 0);
      end
      in_valid = 1'b0;
      for (int i = 3; i < 7; i++) begin
         check("fs_drain", m_data, seq[i]);
         check("fs_drow", m_row, srow[i]);
         step();
         check("fs_done", done, (i == 3));
      end
      check("fs_empty", m_valid, 0);

      // reset mid-vector
      m_ready = 1'b0; in_valid = 1'b1; in_data = 16'h5555;
      step(); step();
      in_valid = 1'b0; rst = 1'b0;
      step();
      check("mr_valid", m_valid, 0);
      check("mr_done", done, 0);
      rst = 1'b1;
      step();
      check("mr_done2", done, 0);
      check("mr_busy", busy, 0);
      m_ready = 1'b1; in_valid = 1'b1; in_data = 16'h461B;
      for (int i = 0; i < 4; i++) begin
         step();
         check("mr_row", m_row, i);
         check("mr_last", m_last, (i == 3));
      end
      in_valid = 1'b0;
      step();
      check("mr_donep", done, 1);

`ifdef BFP16_DRAIN_NAN_CHECK_EN
      // Inf/NaN tracking
      m_ready = 1'b0; in_valid = 1'b1; in_data = 16'h7FC0;
      step();
      check("nan_seen", nan_seen, 1);
      check("nan_head", m_nan, 1);
      in_data = 16'h461B;
      step();
      in_valid = 1'b0; m_ready = 1'b1;
      step();
      check("nan_clr_d", m_data, 16'h461B);
      check("nan_clr", m_nan, 0);
      check("nan_stick", nan_seen, 1);
      step();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/bfp16_col_drain.md
Name: bfp16_col_drain

Overview:
- Receive end of the bfp16 PE column result stream: captures the per-cycle `out` word from `bfp16_pe_col` while the column marks it valid.
- Buffers captured words in a small FIFO, tags each with its output-row index and a last-row flag, and hands them to a downstream writer over a valid/ready handshake.
- Sits between the PE column output and the result writeback path. It is the counterpart of the ifmap/weight/ctrl feeder on the column's input side.

Parameters:
- DATA_TYPE, 16, result word width (bfp16).
- NUM_ROWS, 4, output rows per matrix-vector product; sets the row counter range.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-low reset; rst==0 at a rising clk edge resets the block.
- in_valid  input  1  column result valid this cycle (delayed ctrl).
- in_data  input  DATA_TYPE  column result word (`out`).
- m_valid  output  1  FIFO head valid.
- m_ready  input  1  downstream accepts the head word.
- m_data  output  DATA_TYPE  head result word.
- m_row  output  $clog2(NUM_ROWS)  row index of the head word.
- m_last  output  1  head word is row NUM_ROWS-1.
- done  output  1  one-cycle pulse when a last-row word is popped.
- overflow  output  1  sticky; a valid result was dropped.
- busy  output  1  state != IDLE, or FIFO not empty.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_row=0, m_last=0, done=0, overflow=0, busy=0. Reset also clears the FIFO pointers and count, row counter=0, state=IDLE.
- A reset mid-vector discards all buffered words, with no done pulse.
- Push: when in_valid=1 and (count<DEPTH, or a pop happens in the same cycle). Writes {in_data, row_cnt, row_cnt==NUM_ROWS-1} at wr_ptr.
- Pop: when m_valid && m_ready.
- Full FIFO with simultaneous pop and push: both proceed and count is unchanged.
- Dropped word: in_valid=1, count==DEPTH, and no pop. The word is discarded, overflow is set (sticky until reset), and row_cnt still advances so later words keep their row alignment.
- Latency: a word pushed at edge N is visible on m_valid/m_data after edge N.
- m_* outputs come from a registered array read at rd_ptr. m_valid = (count!=0).
- m_data, m_row and m_last stay stable while m_valid=1 and m_ready=0.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Row counter:
  - Increments on each in_valid cycle (accepted or dropped).
  - Wraps from NUM_ROWS-1 to 0.
  - Stream boundaries are defined solely by this count.
- State machine:
  - IDLE: in_valid=1 -> COLLECT.
  - COLLECT: in_valid=1 with row_cnt==NUM_ROWS-1 -> DRAIN; otherwise stay.
  - DRAIN: pop of a word with last=1 -> IDLE, with done asserted in that same cycle's registered output (done is high the cycle after the pop edge). While in DRAIN, in_valid=1 continues pushing the next vector and also moves to COLLECT once that pop completes. If no last-word pop has happened, stay in DRAIN and keep accepting.
- done is high for exactly one cycle per popped last-row word.
- Gaps (in_valid=0) inside a vector are allowed and do not reset row_cnt.

Optional Feature:
- Macro: BFP16_DRAIN_NAN_CHECK_EN.
- Defined:
  - Adds output port nan_seen (1 bit, reset 0).
  - Sticky-set when an accepted push has exponent field in_data[14:7]==8'hFF (Inf/NaN).
  - Also adds per-entry bit m_nan (1 bit, reset 0) = exponent all-ones of the head word.
- Not defined: neither port exists, there is no extra storage, and behaviour is otherwise identical.

Test Plan:
- Reset and basic vector:
  - Hold rst=0 for 2 cycles -> all outputs 0.
  - Release; drive in_valid=1 for 4 cycles with 0x461B each, m_ready=1.
  - Expect 4 pops with m_data=0x461B, m_row 0,1,2,3, m_last only on row 3, a single done pulse, overflow=0.
- Backpressure and stability:
  - m_ready=0, push 0x3F80, 0x4040, 0x4100, 0x449B -> count=4, and m_data holds 0x3F80 steady for 5 cycles.
  - Then m_ready=1 -> words pop in order.
- Overflow:
  - m_ready=0, push 5 words.
  - The 5th is dropped, overflow=1 from the next cycle and stays 1.
  - The next vector's first word still pops with m_row=1 (row counter kept advancing).
- Full simultaneous push and pop:
  - Fill to 4, then m_ready=1 and in_valid=1 for 3 cycles -> no drops, count stays 4, overflow=0, order preserved.
- Reset mid-vector:
  - After 2 of 4 words, drive rst=0 for 1 cycle -> m_valid=0, no done pulse.
  - A new 4-word vector starts at m_row=0.
- NaN check (with BFP16_DRAIN_NAN_CHECK_EN defined):
  - Push 0x7FC0 -> nan_seen=1, and m_nan=1 when it reaches the head.
  - Push 0x461B -> m_nan=0, while nan_seen stays 1.
